// File: rtl/axis_fp16_vector_streamer.sv
// Buffers up to DEPTH FP16 words and streams them out as one AXI-Stream packet per start command.
// Latency: first beat one cycle after start; stalls on tready=0 or aclken=0 and holds outputs stable.
module axis_fp16_vector_streamer #(
  parameter int DATA_WIDTH  = 16,
  parameter int TUSER_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int LEN_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   aclken,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   length,
  input  logic [TUSER_WIDTH-1:0] tag,
  output logic                   busy,
  output logic                   done,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   idx_q;
  logic [LEN_WIDTH-1:0]   eff_len_d;
  logic                   busy_q;
  logic                   done_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic [TUSER_WIDTH-1:0] tuser_q;

  always_comb begin
    eff_len_d = (length > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : length;
  end

  // Buffer is deliberately not reset so loaded vectors survive a reset.
  always_ff @(posedge aclk) begin
    if (aclken && wr_en && (state_q == IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
    end else if (aclken) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= eff_len_d;
            if (eff_len_d == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              tdata_q  <= mem_q[0];
              tvalid_q <= 1'b1;
              tlast_q  <= (eff_len_d == LEN_WIDTH'(1));
              tuser_q  <= tag;
              idx_q    <= LEN_WIDTH'(1);
              busy_q   <= 1'b1;
              state_q  <= SEND;
            end
          end
        end
        SEND: begin
          // tvalid is always high here, so tready alone marks the handshake.
          if (m_axis_tready) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tuser_q  <= '0;
              idx_q    <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              tdata_q <= mem_q[idx_q[ADDR_WIDTH-1:0]];
              tlast_q <= (idx_q == len_q - LEN_WIDTH'(1));
              idx_q   <= idx_q + LEN_WIDTH'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_fp16_vector_streamer.sv
// Bench for axis_fp16_vector_streamer: table of packets plus hand-written stall, reset and start-collision sequences.
module tb_axis_fp16_vector_streamer;

  localparam int DW = 16;
  localparam int TW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          aclk = 1'b0;
  logic          areset;
  logic          aclken;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [LW-1:0] length;
  logic [TW-1:0] tag;
  logic          busy;
  logic          done;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [TW-1:0] tuser;
  logic          tlast;

  axis_fp16_vector_streamer #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(TW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .length(length), .tag(tag),
    .busy(busy), .done(done),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [TW-1:0] u;
  } beat_t;

  typedef struct {
    int         len;
    logic [3:0] tg;
    int         mode;
    int         exp_k;
  } vec_t;

  beat_t         exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            total = 0;
  int            bad = 0;
  int            done_cnt = 0;
  int            exp_done = 0;
  bit            pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each handshake, and stability check across stalled cycles.
  logic  prev_stall = 1'b0;
  beat_t prev_b;
  beat_t cur_b;
  beat_t exp_b;
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      cur_b = '{d: tdata, l: tlast, u: tuser};
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", {31'd0, tvalid}, 32'd1);
        check("stall_hold", {11'd0, cur_b}, {11'd0, prev_b});
      end
      if (tvalid && tready && aclken) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected none", cur_b);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", {11'd0, cur_b}, {11'd0, exp_b});
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = tvalid;
        prev_b = cur_b;
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_pkt(input int len, input logic [3:0] tg, output int n);
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) exp_q.push_back('{d: mem_m[i], l: (i == n - 1), u: tg});
  endtask

  task automatic wait_done(input string name, input int mode, output int k);
    k = 0;
    while (!done && k < 300) begin
      if (mode == 1) tready = pat[k % 6];
      cyc();
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: done timeout got %0d cycles expected done", name, k);
    end
    tready = 1'b1;
  endtask

  task automatic run_pkt(input string name, input int len, input logic [3:0] tg,
                         input int mode, input int exp_k);
    int n;
    int k;
    push_pkt(len, tg, n);
    start = 1'b1; length = LW'(len); tag = tg;
    cyc();
    start = 1'b0;
    if (n > 0) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_tvalid0"}, {31'd0, tvalid}, 32'd1);
      check({name, "_tuser"}, {28'd0, tuser}, {28'd0, tg});
    end else begin
      check({name, "_zero_done"}, {31'd0, done}, 32'd1);
      check({name, "_zero_tvalid"}, {31'd0, tvalid}, 32'd0);
    end
    wait_done(name, mode, k);
    exp_done++;
    if (exp_k >= 0) check({name, "_latency"}, k, exp_k);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_done_tvalid"}, {31'd0, tvalid}, 32'd0);
    cyc();
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_tuser"}, {28'd0, tuser}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n;
    int   k;
    int   ksum;
    vecs[0] = '{5, 4'd1, 0, 5};
    vecs[1] = '{5, 4'd2, 1, -1};
    vecs[2] = '{0, 4'd3, 0, 0};
    vecs[3] = '{20, 4'd4, 0, 16};
    vecs[4] = '{1, 4'd5, 0, 1};
    vecs[5] = '{16, 4'd6, 0, 16};
    vecs[6] = '{3, 4'd7, 1, -1};

    areset = 1'b1; aclken = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; length = '0; tag = '0; tready = 1'b1;
    #1;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tdata", {16'd0, tdata}, 32'd0);
    check("rst_tuser", {28'd0, tuser}, 32'd0);
    cyc();
    cyc();
    areset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: mem_m[i] = 16'h3C00;
        1: mem_m[i] = 16'h4000;
        2: mem_m[i] = 16'h4200;
        3: mem_m[i] = 16'h4400;
        4: mem_m[i] = 16'h4500;
        default: mem_m[i] = 16'h5000 + 16'(i);
      endcase
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = mem_m[i];
      cyc();
    end
    wr_en = 1'b0;
    cyc();

    for (int v = 0; v < 7; v++) begin
      run_pkt($sformatf("vec%0d", v), vecs[v].len, vecs[v].tg, vecs[v].mode, vecs[v].exp_k);
    end

    // aclken freeze mid-packet plus a write attempt while sending.
    push_pkt(5, 4'd8, n);
    start = 1'b1; length = LW'(5); tag = 4'd8;
    cyc();
    start = 1'b0;
    cyc();
    aclken = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("freeze_tdata", {16'd0, tdata}, {16'd0, mem_m[1]});
    aclken = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = 16'hDEAD;
    cyc();
    wr_en = 1'b0;
    wait_done("freeze", 0, k);
    exp_done++;
    check("freeze_latency", 1 + 3 + 1 + k, 8);
    check("freeze_drained", exp_q.size(), 0);
    cyc();
    run_pkt("readback", 5, 4'd9, 0, 5);

    // Second start while busy and a start during DONE are both ignored.
    push_pkt(4, 4'hA, n);
    start = 1'b1; length = LW'(4); tag = 4'hA;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; length = LW'(2); tag = 4'hB;
    cyc();
    start = 1'b0;
    wait_done("busy_start", 0, k);
    exp_done++;
    start = 1'b1; length = LW'(3); tag = 4'hB;
    cyc();
    start = 1'b0;
    check("done_start_tvalid", {31'd0, tvalid}, 32'd0);
    check("done_start_busy", {31'd0, busy}, 32'd0);
    cyc();
    check("busy_start_tvalid", {31'd0, tvalid}, 32'd0);
    check("busy_start_drained", exp_q.size(), 0);

    // Async reset after two beats of a five-beat packet.
    push_pkt(5, 4'hC, n);
    start = 1'b1; length = LW'(5); tag = 4'hC;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2;
    areset = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, tvalid}, 32'd0);
    check("arst_tlast", {31'd0, tlast}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_tuser", {28'd0, tuser}, 32'd0);
    check("arst_consumed", exp_q.size(), 3);
    exp_q.delete();
    cyc();
    areset = 1'b0;
    cyc();
    run_pkt("post_reset", 2, 4'hD, 0, 2);

    // Write and start on the same edge: packet uses old buf[0], write still lands.
    push_pkt(2, 4'hE, n);
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'h4800;
    start = 1'b1; length = LW'(2); tag = 4'hE;
    cyc();
    wr_en = 1'b0; start = 1'b0;
    mem_m[0] = 16'h4800;
    wait_done("same_edge", 0, k);
    exp_done++;
    check("same_edge_latency", k, 2);
    cyc();
    run_pkt("same_edge_rb", 1, 4'hF, 0, 1);

    cyc();
    check("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
